fifo_read_arbiter: RTL and testbench
====================================

Name: fifo_read_arbiter

Overview:
- Round-robin arbiter that shares one downstream consumer between NUM_FIFOS FIFOs.
- Each FIFO's read-pointer logic exposes an empty flag and accepts a read enable. The arbiter watches all empty flags and consumer ready, then raises at most one ren per cycle.
- A one-cycle-delayed tag identifies the source of the word the consumer receives.
- Sits between the NPU's per-lane input FIFOs and the shared operand-load path.

Parameters:
- NUM_FIFOS, 4, number of requesting FIFOs; legal range 2 to 16.
- IDX_WIDTH, $clog2(NUM_FIFOS), width of grant index outputs.
- BURST_LEN, 4, maximum consecutive reads from one FIFO; used only when FIFO_ARB_BURST_EN is defined; legal range 1 to 255.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- empty  input  NUM_FIFOS  per-FIFO empty flag; bit i high means FIFO i holds no data.
- ready  input  1  consumer can accept a word this cycle.
- ren  output  NUM_FIFOS  one-hot-or-zero read enable to FIFO i; combinational.
- grant_valid  output  1  a read is issued this cycle; combinational, equal to OR of ren.
- grant_idx  output  IDX_WIDTH  index of the FIFO read this cycle; combinational; 0 when grant_valid is low.
- rd_valid  output  1  grant_valid delayed by one cycle; registered.
- rd_idx  output  IDX_WIDTH  grant_idx delayed by one cycle; registered.

Behaviour:
- State:
  - prio register (IDX_WIDTH bits) holds the highest-priority index for the next arbitration.
  - rd_valid and rd_idx registers.
  - In burst builds only: lock flag, lock_idx, and burst_cnt (8 bits).
- Reset:
  - prio=0, rd_valid=0, rd_idx=0, lock=0, lock_idx=0, burst_cnt=0.
  - Combinational outputs follow from these values, so ren=0 whenever ready=0 or all FIFOs are empty.
- Selection:
  - Candidate set is the bits i where empty[i]==0.
  - sel is the first candidate found scanning prio, prio+1, … with wrap modulo NUM_FIFOS. The scan must wrap correctly for non-power-of-2 NUM_FIFOS.
- Issue:
  - If ready==1 and the candidate set is non-empty: ren[sel]=1, grant_valid=1, grant_idx=sel.
  - Otherwise all ren bits are 0, grant_valid=0, grant_idx=0.
  - ren is never asserted to an empty FIFO.
  - ren is never asserted while ready==0.
- Pointer update:
  - On a cycle with grant_valid=1, prio <= (sel==NUM_FIFOS-1) ? 0 : sel+1.
  - On a cycle with grant_valid=0, prio holds.
- Output pipeline: every cycle rd_valid <= grant_valid and rd_idx <= grant_idx. Latency from ren to tag is exactly 1 cycle.
- Fairness: with all FIFOs continuously non-empty and ready held high, grants cycle 0,1,…,N-1,0,… with no gaps.
- Edge cases:
  - A FIFO that goes empty is skipped the same cycle.
  - A FIFO that refills in cycle t is eligible in cycle t.
  - When rst and ready are both high in one cycle, rst dominates: the next state is the reset state and no side effects persist.
  - Asserting rst mid-stream drops any pending rd_valid tag on the next edge.

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- Defined: two-state FSM, ARB and LOCK.
  - ARB: selection and grant proceed as above. On a grant, if BURST_LEN>1 then lock<=1, lock_idx<=sel, burst_cnt<=1 and the FSM enters LOCK. prio updates as normal.
  - LOCK, when ready==1 and empty[lock_idx]==0: ren[lock_idx]=1 and burst_cnt increments. When burst_cnt+1==BURST_LEN, return to ARB.
  - LOCK, when ready==0: hold all state; no grant.
  - LOCK, when empty[lock_idx]==1: return to ARB in the same cycle and arbitrate normally that cycle, so there is no dead cycle.
  - prio is not modified while in LOCK.
- Not defined: lock, lock_idx and burst_cnt do not exist. Every grant rotates priority, which is equivalent to BURST_LEN=1.

Test Plan:
- Reset, then empty=4'b0000 with ready=1 for 8 cycles → grant_idx sequence 0,1,2,3,0,1,2,3; rd_idx lags by one cycle; ren is one-hot every cycle.
- empty=4'b1010, ready=1, 4 cycles → grants 0,2,0,2; ren[1] and ren[3] are never high.
- empty=4'b0000 with ready toggling 1,0,1,0 → grants 0,–,1,–; prio holds during ready=0 cycles; ren=0 when ready=0.
- After a grant to 3, set empty=4'b1110 → next grant is 0 (wrap). With NUM_FIFOS=3 and prio=2, grant 2 then 0.
- Assert rst in the same cycle as a grant → next cycle rd_valid=0, prio=0, and the first post-reset grant goes to the lowest non-empty index.
- With FIFO_ARB_BURST_EN, BURST_LEN=3 and all FIFOs non-empty:
  - Grants 0,0,0,1,1,1,2,…
  - Emptying FIFO 1 after its 2nd read gives grant 2 on the next cycle with no bubble.

Source files
------------

// File: rtl/fifo_read_arbiter_if.sv
// Handshake bundle between the per-lane FIFO read ports, the shared consumer
// and the round-robin read arbiter. The arbiter connects through the master
// modport; the FIFO/consumer side connects through the slave modport.
interface fifo_read_arbiter_if #(
    parameter int NUM_FIFOS = 4,
    parameter int IDX_WIDTH = $clog2(NUM_FIFOS)
);
    logic [NUM_FIFOS-1:0] empty;
    logic                 ready;
    logic [NUM_FIFOS-1:0] ren;
    logic                 grant_valid;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic                 rd_valid;
    logic [IDX_WIDTH-1:0] rd_idx;

    modport master (
        input  empty, ready,
        output ren, grant_valid, grant_idx, rd_valid, rd_idx
    );

    modport slave (
        output empty, ready,
        input  ren, grant_valid, grant_idx, rd_valid, rd_idx
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin read arbiter sharing one consumer between NUM_FIFOS FIFOs.
// At most one read enable per cycle; the source tag follows one cycle later.
// Optional build macro FIFO_ARB_BURST_EN: after a grant, stay on the same
// FIFO for up to BURST_LEN consecutive reads before rotating.
module fifo_read_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int IDX_WIDTH = $clog2(NUM_FIFOS),
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_read_arbiter_if.master bus
);

    if (NUM_FIFOS < 2 || NUM_FIFOS > 16 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_params
        $error("fifo_read_arbiter: parameter out of range");
    end

    // Returns {found, index} of the first set bit scanning from start with wrap.
    function automatic logic [IDX_WIDTH:0] first_candidate(
        input logic [NUM_FIFOS-1:0] cand,
        input logic [IDX_WIDTH-1:0] start
    );
        logic [IDX_WIDTH:0] res;
        int unsigned        pos;
        res = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            pos = int'(start) + k;
            if (pos >= NUM_FIFOS) pos = pos - NUM_FIFOS;
            if (!res[IDX_WIDTH] && cand[IDX_WIDTH'(pos)]) res = {1'b1, IDX_WIDTH'(pos)};
        end
        return res;
    endfunction

    logic [IDX_WIDTH-1:0] prio_q, prio_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_WIDTH:0]   pick;
    logic                 arbitrate;
    logic                 gnt_valid;
    logic [IDX_WIDTH-1:0] gnt_idx;
    logic [NUM_FIFOS-1:0] ren;

`ifdef FIFO_ARB_BURST_EN
    typedef enum logic {ARB, LOCK} state_t;
    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
`endif

    // Grant selection, next-state computation and read-enable decode.
    always_comb begin
        pick      = first_candidate(~bus.empty, prio_q);
        arbitrate = 1'b1;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        prio_d    = prio_q;
`ifdef FIFO_ARB_BURST_EN
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        burst_cnt_d = burst_cnt_q;
        // A locked FIFO that has run dry releases the lock and falls through
        // to normal arbitration in the same cycle, so no bubble is inserted.
        if (state_q == LOCK) begin
            if (!bus.ready) begin
                arbitrate = 1'b0;
            end else if (!bus.empty[lock_idx_q]) begin
                arbitrate = 1'b0;
                gnt_valid = 1'b1;
                gnt_idx   = lock_idx_q;
                if ({1'b0, burst_cnt_q} + 9'd1 == 9'(BURST_LEN)) begin
                    state_d     = ARB;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end else begin
                state_d = ARB;
            end
        end
`endif
        if (arbitrate && bus.ready && pick[IDX_WIDTH]) begin
            gnt_valid = 1'b1;
            gnt_idx   = pick[IDX_WIDTH-1:0];
            prio_d    = (gnt_idx == IDX_WIDTH'(NUM_FIFOS - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef FIFO_ARB_BURST_EN
            if (BURST_LEN > 1) begin
                state_d     = LOCK;
                lock_idx_d  = gnt_idx;
                burst_cnt_d = 8'd1;
            end
`endif
        end
        rd_valid_d = gnt_valid;
        rd_idx_d   = gnt_idx;
        ren        = '0;
        if (gnt_valid) ren[gnt_idx] = 1'b1;
    end

    // State registers; reset overrides any grant in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_idx_q    <= '0;
`ifdef FIFO_ARB_BURST_EN
            state_q     <= ARB;
            lock_idx_q  <= '0;
            burst_cnt_q <= '0;
`endif
        end else begin
            prio_q      <= prio_d;
            rd_valid_q  <= rd_valid_d;
            rd_idx_q    <= rd_idx_d;
`ifdef FIFO_ARB_BURST_EN
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            burst_cnt_q <= burst_cnt_d;
`endif
        end
    end

    assign bus.ren         = ren;
    assign bus.grant_valid = gnt_valid;
    assign bus.grant_idx   = gnt_idx;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_idx      = rd_idx_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter against a queue-free behavioural
// model of round-robin service (with optional burst locking).
module tb_fifo_read_arbiter;

`ifdef FIFO_ARB_BURST_EN
    localparam int TB_BL = 3;
`else
    localparam int TB_BL = 1;
`endif

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    fifo_read_arbiter_if #(.NUM_FIFOS(4), .IDX_WIDTH(2)) bus ();
    fifo_read_arbiter_if #(.NUM_FIFOS(3), .IDX_WIDTH(2)) bus3 ();

    fifo_read_arbiter #(.NUM_FIFOS(4), .IDX_WIDTH(2), .BURST_LEN(3)) dut (
        .clk(clk), .rst(rst), .bus(bus.master));

    fifo_read_arbiter #(.NUM_FIFOS(3), .IDX_WIDTH(2), .BURST_LEN(1)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: next favoured source, current burst owner, reads left.
    int         m_prio = 0;
    int         m_lock = -1;
    int         m_left = 0;
    logic       m_rdv = 1'b0;
    logic [1:0] m_rdi = 2'd0;

    function automatic int model_pick(input logic [3:0] e, input logic r);
        int i;
        if (!r) return -1;
        if (m_lock >= 0 && !e[m_lock]) return m_lock;
        for (int k = 0; k < 4; k++) begin
            i = (m_prio + k) % 4;
            if (!e[i]) return i;
        end
        return -1;
    endfunction

    // {ren[3:0], grant_valid, grant_idx[1:0], rd_valid, rd_idx[1:0]}
    function automatic logic [9:0] model_expect(input logic [3:0] e, input logic r);
        int         g;
        logic [3:0] er;
        g  = model_pick(e, r);
        er = (g >= 0) ? 4'(1 << g) : 4'd0;
        return {er, (g >= 0), (g >= 0) ? 2'(g) : 2'd0, m_rdv, m_rdi};
    endfunction

    function automatic logic [9:0] observed();
        return {bus.ren, bus.grant_valid, bus.grant_idx, bus.rd_valid, bus.rd_idx};
    endfunction

    task automatic model_update(input logic [3:0] e, input logic r, input logic s);
        int g;
        bit locked_path;
        g           = model_pick(e, r);
        locked_path = (m_lock >= 0) && r && !e[m_lock];
        if (s) begin
            m_prio = 0; m_lock = -1; m_left = 0; m_rdv = 1'b0; m_rdi = 2'd0;
            return;
        end
        m_rdv = (g >= 0);
        m_rdi = (g >= 0) ? 2'(g) : 2'd0;
        if (locked_path) begin
            m_left--;
            if (m_left == 0) m_lock = -1;
        end else if (g >= 0) begin
            m_prio = (g + 1) % 4;
            m_lock = -1;
            if (TB_BL > 1) begin
                m_lock = g;
                m_left = TB_BL - 1;
            end
        end else if (m_lock >= 0 && r) begin
            m_lock = -1;
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic r, input logic s);
        bus.empty = e;
        bus.ready = r;
        rst       = s;
        @(negedge clk);
    endtask

    task automatic tick(input logic [3:0] e, input logic r, input logic s);
        model_update(e, r, s);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus3.empty = 3'b111;
        bus3.ready = 1'b0;
        drive(4'b1111, 1'b0, 1'b1);
        tick(4'b1111, 1'b0, 1'b1);
        drive(4'b1111, 1'b1, 1'b1);
        tests++;
        if (observed() !== 10'd0) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", observed(), 10'd0);
        end
        tick(4'b1111, 1'b1, 1'b1);
    endtask

    task automatic test_fairness();
        logic [9:0] exp_v;
        for (int k = 0; k < 8; k++) begin
            drive(4'b0000, 1'b1, 1'b0);
            exp_v = model_expect(4'b0000, 1'b1);
            tests++;
            if (observed() !== exp_v || !$onehot(bus.ren)) begin
                fails++;
                $display("FAIL fairness[%0d]: got %b expected %b", k, observed(), exp_v);
            end
            tick(4'b0000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_sparse();
        logic [9:0] exp_v;
        for (int k = 0; k < 4; k++) begin
            drive(4'b1010, 1'b1, 1'b0);
            exp_v = model_expect(4'b1010, 1'b1);
            tests++;
            if (observed() !== exp_v || (bus.ren[1] | bus.ren[3]) !== 1'b0) begin
                fails++;
                $display("FAIL sparse[%0d]: got %b expected %b", k, observed(), exp_v);
            end
            tick(4'b1010, 1'b1, 1'b0);
        end
    endtask

    task automatic test_ready_toggle();
        logic [9:0] exp_v;
        logic       r;
        for (int k = 0; k < 6; k++) begin
            r = (k % 2 == 0);
            drive(4'b0000, r, 1'b0);
            exp_v = model_expect(4'b0000, r);
            tests++;
            if (observed() !== exp_v || (!r && bus.ren !== 4'd0)) begin
                fails++;
                $display("FAIL ready_toggle[%0d]: got %b expected %b", k, observed(), exp_v);
            end
            tick(4'b0000, r, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp_v;
        logic [3:0] seq_e [3] = '{4'b0111, 4'b1110, 4'b1110};
        for (int k = 0; k < 3; k++) begin
            drive(seq_e[k], 1'b1, 1'b0);
            exp_v = model_expect(seq_e[k], 1'b1);
            tests++;
            if (observed() !== exp_v || bus.grant_idx !== ((k == 0) ? 2'd3 : 2'd0)) begin
                fails++;
                $display("FAIL wrap[%0d]: got %b expected %b", k, observed(), exp_v);
            end
            tick(seq_e[k], 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_during_grant();
        logic [9:0] exp_v;
        drive(4'b0000, 1'b1, 1'b0);
        tick(4'b0000, 1'b1, 1'b0);
        drive(4'b0000, 1'b1, 1'b1);
        exp_v = model_expect(4'b0000, 1'b1);
        tests++;
        if (observed() !== exp_v) begin
            fails++;
            $display("FAIL rst_with_grant: got %b expected %b", observed(), exp_v);
        end
        tick(4'b0000, 1'b1, 1'b1);
        drive(4'b1100, 1'b1, 1'b0);
        exp_v = model_expect(4'b1100, 1'b1);
        tests++;
        if (observed() !== exp_v || bus.rd_valid !== 1'b0 || bus.grant_idx !== 2'd0) begin
            fails++;
            $display("FAIL post_reset_grant: got %b expected %b", observed(), exp_v);
        end
        tick(4'b1100, 1'b1, 1'b0);
    endtask

`ifdef FIFO_ARB_BURST_EN
    task automatic test_burst();
        int         exp_g [6] = '{0, 0, 0, 1, 1, 2};
        logic [3:0] e;
        drive(4'b1111, 1'b0, 1'b1);
        tick(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            e = (k == 5) ? 4'b0010 : 4'b0000;
            drive(e, 1'b1, 1'b0);
            tests++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 2'(exp_g[k]) ||
                observed() !== model_expect(e, 1'b1)) begin
                fails++;
                $display("FAIL burst[%0d]: got idx %0d valid %b expected idx %0d",
                         k, bus.grant_idx, bus.grant_valid, exp_g[k]);
            end
            tick(e, 1'b1, 1'b0);
        end
    endtask
`endif

    task automatic test_random();
        logic [9:0] exp_v;
        logic [3:0] e;
        logic       r;
        logic       s;
        for (int k = 0; k < 120; k++) begin
            e = 4'($urandom_range(0, 15));
            r = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 24) == 0);
            drive(e, r, s);
            exp_v = model_expect(e, r);
            tests++;
            if (observed() !== exp_v) begin
                fails++;
                $display("FAIL random[%0d] e=%b r=%b: got %b expected %b", k, e, r, observed(), exp_v);
            end
            tick(e, r, s);
        end
    endtask

    task automatic test_n3_wrap();
        logic [4:0] exp_v;
        bus3.empty = 3'b000;
        bus3.ready = 1'b1;
        drive(4'b1111, 1'b0, 1'b1);
        tick(4'b1111, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b0, 1'b0);
            exp_v = {3'(1 << (k % 3)), 2'(k % 3)};
            tests++;
            if ({bus3.ren, bus3.grant_idx} !== exp_v || bus3.grant_valid !== 1'b1 ||
                (k > 0 && bus3.rd_idx !== 2'((k - 1) % 3))) begin
                fails++;
                $display("FAIL n3_wrap[%0d]: got %b expected %b", k, {bus3.ren, bus3.grant_idx}, exp_v);
            end
            tick(4'b1111, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.empty  = 4'b1111;
        bus.ready  = 1'b0;
        bus3.empty = 3'b111;
        bus3.ready = 1'b0;
        test_reset();
        test_fairness();
        test_sparse();
        test_ready_toggle();
        test_wrap();
        test_reset_during_grant();
`ifdef FIFO_ARB_BURST_EN
        test_burst();
`endif
        test_random();
        test_n3_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
